// File: rtl/data_memory_mmio.sv
// Hack-style data memory: RAM, framebuffer with a handshaked scanout engine, and a keyboard register.
// Define KBD_FIFO_EN to replace the last-wins keyboard register with a popped FIFO.
module data_memory_mmio #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 15,
  parameter int SCREEN_BASE    = 16384,
  parameter int SCREEN_WORDS   = 8192,
  parameter int KBD_ADDR       = 24576,
  parameter int KBD_FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load,
  input  logic [ADDR_W-1:0]               adr,
  input  logic [DATA_W-1:0]               d_in,
  output logic [DATA_W-1:0]               d_out,
  input  logic [DATA_W-1:0]               kb_code,
  input  logic                            kb_strobe,
  output logic                            kb_overflow,
  input  logic                            scan_start,
  output logic [DATA_W-1:0]               scan_word,
  output logic [$clog2(SCREEN_WORDS)-1:0] scan_addr,
  output logic                            scan_valid,
  input  logic                            scan_ready,
  output logic                            scan_busy,
  output logic                            frame_done
);

  localparam int SW = $clog2(SCREEN_WORDS);
  localparam logic [ADDR_W-1:0] KBD_A    = ADDR_W'(KBD_ADDR);
  localparam logic [ADDR_W-1:0] SCR_A    = ADDR_W'(SCREEN_BASE);
  localparam logic [SW-1:0]     LAST_IDX = SW'(SCREEN_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT, S_DONE} scan_state_t;

  logic [DATA_W-1:0] mem [KBD_ADDR];
  logic [DATA_W-1:0] kbd_val;
  scan_state_t       state, state_n;
  logic [SW-1:0]     idx;

  always_ff @(posedge clk) begin
    if (load && adr < KBD_A) mem[adr] <= d_in;
  end

  always_comb begin
    d_out = '0;
    if (adr < KBD_A)       d_out = mem[adr];
    else if (adr == KBD_A) d_out = kbd_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    scan_valid = 1'b0;
    scan_busy  = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE:    if (scan_start) state_n = S_FETCH;
      S_FETCH: begin
        scan_busy = 1'b1;
        state_n   = S_PRESENT;
      end
      S_PRESENT: begin
        scan_busy  = 1'b1;
        scan_valid = 1'b1;
        if (scan_ready) state_n = (idx == LAST_IDX) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_n    = S_IDLE;
      end
      default:   state_n = S_IDLE;
    endcase
  end

  // The fetch samples mem with a non-blocking read, so a same-cycle CPU write is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      scan_word <= '0;
      scan_addr <= '0;
    end else begin
      case (state)
        S_IDLE:    if (scan_start) idx <= '0;
        S_FETCH: begin
          scan_word <= mem[SCR_A + ADDR_W'(idx)];
          scan_addr <= idx;
        end
        S_PRESENT: if (scan_ready && idx != LAST_IDX) idx <= idx + 1'b1;
        default:   ;
      endcase
    end
  end

`ifdef KBD_FIFO_EN
  localparam int PW = $clog2(KBD_FIFO_DEPTH);

  logic [DATA_W-1:0] fifo [KBD_FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [PW:0]       count;
  logic              empty, full, pop, push, ovf;

  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(KBD_FIFO_DEPTH));
  assign pop   = load && (adr == KBD_A) && !empty;
  // A pop frees the slot before the push lands, so push+pop on full is accepted.
  assign push  = kb_strobe && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= kb_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (kb_strobe && !push) ovf <= 1'b1;
    end
  end

  assign kbd_val     = empty ? '0 : fifo[rd_ptr];
  assign kb_overflow = ovf;
`else
  logic [DATA_W-1:0] kbd_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         kbd_reg <= '0;
    else if (kb_strobe) kbd_reg <= kb_code;
  end

  assign kbd_val     = kbd_reg;
  assign kb_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_mmio.sv
// Self-checking bench for data_memory_mmio: vector table, randomized CPU/keyboard traffic
// against an array/queue model, and hand-written scanout and reset sequences.
module tb_data_memory_mmio;

  localparam int DW = 16, AW = 15, SB = 16384, SWD = 8192, KA = 24576, DEPTH = 4;

  logic          clk = 1'b0, rst_n = 1'b0, load = 1'b0;
  logic [AW-1:0] adr = '0;
  logic [DW-1:0] d_in = '0, kb_code = '0;
  logic          kb_strobe = 1'b0, scan_start = 1'b0, scan_ready = 1'b0;
  logic [DW-1:0] d_out, scan_word;
  logic [12:0]   scan_addr;
  logic          kb_overflow, scan_valid, scan_busy, frame_done;

  data_memory_mmio #(
    .DATA_W(DW), .ADDR_W(AW), .SCREEN_BASE(SB), .SCREEN_WORDS(SWD),
    .KBD_ADDR(KA), .KBD_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .adr(adr), .d_in(d_in), .d_out(d_out),
    .kb_code(kb_code), .kb_strobe(kb_strobe), .kb_overflow(kb_overflow),
    .scan_start(scan_start), .scan_word(scan_word), .scan_addr(scan_addr),
    .scan_valid(scan_valid), .scan_ready(scan_ready), .scan_busy(scan_busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: flat word array plus keyboard queue / last-value register.
  logic [DW-1:0] mdl  [KA];
  bit            wr_ok[KA];
  logic [DW-1:0] snap [SWD];
  logic [DW-1:0] kq[$];
  logic [DW-1:0] kb_m = '0;
  bit            ovf_m = 1'b0;

  function automatic logic [DW-1:0] kbd_exp();
`ifdef KBD_FIFO_EN
    return (kq.size() > 0) ? kq[0] : '0;
`else
    return kb_m;
`endif
  endfunction

  function automatic logic [DW-1:0] read_exp(input int a);
    if (a < KA)  return mdl[a];
    if (a == KA) return kbd_exp();
    return '0;
  endfunction

  task automatic model_edge();
`ifdef KBD_FIFO_EN
    if (load && int'(adr) == KA && kq.size() > 0) void'(kq.pop_front());
    if (kb_strobe) begin
      if (kq.size() < DEPTH) kq.push_back(kb_code);
      else                   ovf_m = 1'b1;
    end
`else
    if (kb_strobe) kb_m = kb_code;
`endif
    if (load && int'(adr) < KA) begin
      mdl[adr]   = d_in;
      wr_ok[adr] = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    kq.delete();
    kb_m  = '0;
    ovf_m = 1'b0;
  endtask

  typedef struct {
    logic          ld;
    int            a;
    logic [DW-1:0] din;
    logic          stb;
    logic [DW-1:0] code;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl[12];

  // Runs one full frame; corner adds a collision write at idx 7, a 10-cycle stall at idx 100
  // with a write to that word, a stray scan_start mid-frame and one during DONE.
  task automatic run_frame(input bit corner, input string tag);
    int  cycles, beats, stall, done_cnt;
    bit  wr_pending;
    for (int k = 0; k < SWD; k++) snap[k] = mdl[SB + k];
    cycles = 1; beats = 0; stall = 0; done_cnt = 0; wr_pending = 1'b0;
    @(negedge clk) scan_start = 1'b1; scan_ready = 1'b1;
    #1 chk({tag, "_busy_pre"}, scan_busy, 1'b0);
    @(negedge clk) scan_start = 1'b0;
    #1 chk({tag, "_busy_rise"}, scan_busy, 1'b1);
    while (cycles < 20000) begin
      load = 1'b0; scan_ready = 1'b1; scan_start = 1'b0;
      if (wr_pending) begin
        load = 1'b1; adr = AW'(SB + 7); d_in = 16'hFFFF;
        model_edge();
        wr_pending = 1'b0;
      end
      if (frame_done) begin
        done_cnt++;
        if (corner) scan_start = 1'b1;
        break;
      end
      if (scan_valid) begin
        if (corner && scan_addr == 13'd100 && stall < 10) begin
          scan_ready = 1'b0;
          if (stall == 0) begin
            load = 1'b1; adr = AW'(SB + 100); d_in = 16'hDEAD;
            model_edge();
          end
          chk({tag, "_stall_word"}, scan_word, snap[100]);
          chk({tag, "_stall_addr"}, scan_addr, 100);
          stall++;
        end else begin
          chk({tag, "_scan_addr"}, scan_addr, beats);
          chk({tag, "_scan_word"}, scan_word, snap[beats]);
          if (corner && beats == 6)  wr_pending = 1'b1;
          if (corner && beats == 50) scan_start = 1'b1;
          beats++;
        end
      end
      @(negedge clk);
      cycles++;
    end
    chk({tag, "_frame_done"}, done_cnt, 1);
    chk({tag, "_beats"}, beats, SWD);
    chk({tag, "_cycles"}, cycles, 16385 + (corner ? 10 : 0));
    @(negedge clk) scan_start = 1'b0; load = 1'b0;
    #1 chk({tag, "_done_pulse"}, frame_done, 1'b0);
    chk({tag, "_busy_after"}, scan_busy, 1'b0);
    @(negedge clk);
    #1 chk({tag, "_no_restart"}, scan_busy, 1'b0);
    chk({tag, "_no_valid"}, scan_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    // Reset state
    adr = AW'(KA);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", scan_valid, 1'b0);
    chk("rst_busy", scan_busy, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_addr", scan_addr, 0);
    chk("rst_word", scan_word, 0);
    chk("rst_ovf", kb_overflow, 1'b0);
    chk("rst_kbd", d_out, 0);
    @(negedge clk) rst_n = 1'b1;

    // Vector table: {load, adr, d_in, strobe, code, expected d_out after the edge}
    tbl[0]  = '{1'b1, 5,     16'h1234, 1'b0, 16'h0000, 16'h1234};
    tbl[1]  = '{1'b1, 24577, 16'hBEEF, 1'b0, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b1, 16383, 16'hA5A5, 1'b0, 16'h0000, 16'hA5A5};
    tbl[3]  = '{1'b1, 24575, 16'h5A5A, 1'b0, 16'h0000, 16'h5A5A};
    tbl[4]  = '{1'b1, 32767, 16'h0001, 1'b0, 16'h0000, 16'h0000};
    tbl[5]  = '{1'b0, KA,    16'h0000, 1'b1, 16'h0041, 16'h0041};
`ifdef KBD_FIFO_EN
    tbl[6]  = '{1'b0, KA,    16'h0000, 1'b1, 16'h0080, 16'h0041};
    tbl[7]  = '{1'b1, KA,    16'h7777, 1'b0, 16'h0000, 16'h0080};
    tbl[8]  = '{1'b1, KA,    16'h7777, 1'b0, 16'h0000, 16'h0000};
`else
    tbl[6]  = '{1'b0, KA,    16'h0000, 1'b1, 16'h0080, 16'h0080};
    tbl[7]  = '{1'b1, KA,    16'h7777, 1'b0, 16'h0000, 16'h0080};
    tbl[8]  = '{1'b1, KA,    16'h7777, 1'b0, 16'h0000, 16'h0080};
`endif
    tbl[9]  = '{1'b0, KA,    16'h0000, 1'b1, 16'h0000, 16'h0000};
    tbl[10] = '{1'b0, 5,     16'h0000, 1'b0, 16'h0000, 16'h1234};
    tbl[11] = '{1'b1, SB,    16'hC3C3, 1'b0, 16'h0000, 16'hC3C3};
    foreach (tbl[i]) begin
      @(negedge clk);
      load = tbl[i].ld; adr = AW'(tbl[i].a); d_in = tbl[i].din;
      kb_strobe = tbl[i].stb; kb_code = tbl[i].code;
      model_edge();
      @(posedge clk);
      #1 load = 1'b0; kb_strobe = 1'b0;
      #1 chk($sformatf("vec%0d", i), d_out, tbl[i].exp);
    end

    // Randomized CPU and keyboard traffic against the model
    for (int i = 0; i < 400; i++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 9);
      if (r < 6)       adr = AW'($urandom_range(0, 63));
      else if (r == 6) adr = AW'($urandom_range(0, KA - 1));
      else if (r == 7) adr = AW'(KA);
      else if (r == 8) adr = AW'($urandom_range(KA + 1, 32767));
      else             adr = AW'(SB + $urandom_range(0, 63));
      load      = ($urandom_range(0, 3) == 0);
      d_in      = DW'($urandom);
      kb_strobe = ($urandom_range(0, 3) == 0);
      kb_code   = DW'($urandom);
      #1;
      if (int'(adr) >= KA || wr_ok[adr]) chk("rand_dout", d_out, read_exp(int'(adr)));
      chk("rand_ovf", kb_overflow, ovf_m);
      model_edge();
    end
    @(negedge clk) load = 1'b0; kb_strobe = 1'b0;

`ifdef KBD_FIFO_EN
    do_reset();
    adr = AW'(KA);
    for (int c = 10; c <= 13; c++) begin
      @(negedge clk) kb_strobe = 1'b1; kb_code = DW'(c);
    end
    @(negedge clk) kb_strobe = 1'b1; kb_code = 16'd14; load = 1'b1;
    @(negedge clk) kb_strobe = 1'b0; load = 1'b0;
    #1 chk("fifo_pushpop_ovf", kb_overflow, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1 chk("fifo_drain_a", d_out, (k < 4) ? 11 + k : 0);
      @(negedge clk) load = 1'b1;
      @(negedge clk) load = 1'b0;
    end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk) kb_strobe = 1'b1; kb_code = DW'(c);
    end
    @(negedge clk) kb_strobe = 1'b0;
    #1 chk("fifo_overflow", kb_overflow, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1 chk("fifo_drain_b", d_out, (k < 4) ? k + 1 : 0);
      @(negedge clk) load = 1'b1;
      @(negedge clk) load = 1'b0;
    end
    #1 chk("fifo_ovf_sticky", kb_overflow, 1'b1);
`endif

    // Fill framebuffer word k with k, then scan twice
    for (int k = 0; k < SWD; k++) begin
      @(negedge clk) load = 1'b1; adr = AW'(SB + k); d_in = DW'(k);
      model_edge();
    end
    @(negedge clk) load = 1'b0;
    run_frame(1'b1, "f1");
    adr = AW'(SB + 7);
    #1 chk("cpu_sees_ffff", d_out, 16'hFFFF);
    run_frame(1'b0, "f2");

    // Reset mid-scan
    @(negedge clk) scan_start = 1'b1; scan_ready = 1'b1;
    @(negedge clk) scan_start = 1'b0;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", scan_busy, 1'b0);
    chk("midrst_valid", scan_valid, 1'b0);
    chk("midrst_done", frame_done, 1'b0);
    chk("midrst_addr", scan_addr, 0);
    chk("midrst_word", scan_word, 0);
    @(negedge clk) rst_n = 1'b1;
    kq.delete(); kb_m = '0; ovf_m = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (frame_done) seen++;
    end
    chk("midrst_no_done", seen, 0);
    chk("midrst_idle", scan_busy, 1'b0);
    adr = AW'(5);
    #1 chk("ram_kept", d_out, mdl[5]);
    adr = AW'(KA);
    #1 chk("kbd_cleared", d_out, 0);
    chk("ovf_cleared", kb_overflow, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
